// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: opcode encodings and ConfigBits field positions for pipe_alu.
package pipe_alu_pkg;
    localparam int OPC_W      = 3;
    localparam int ADDEND_SEL = 3;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
    localparam logic [OPC_W-1:0] OP_AND = 3'd2;
    localparam logic [OPC_W-1:0] OP_OR  = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_MUL = 3'd5;
    localparam logic [OPC_W-1:0] OP_MAC = 3'd6;
    localparam logic [OPC_W-1:0] OP_ACC = 3'd7;

    function automatic logic is_acc_op(input logic [OPC_W-1:0] op);
        return op == OP_MAC || op == OP_ACC;
    endfunction
endpackage

// File: rtl/pipe_alu_stage.sv
// pipe_alu_stage: one valid/data pipeline register with load-enable and ready-out.
module pipe_alu_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ready_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        ready_out = en && (!valid_q || ready_in);
        valid_d   = ready_out ? valid_in : valid_q;
        data_d    = (ready_out && valid_in) ? data_in : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: pipelined ALU with valid/ready handshake and MAC/ACC accumulator.
module pipe_alu
    import pipe_alu_pkg::*;
#(
    parameter int NoConfigBits = 3,
    parameter int WIDTH        = 32,
    parameter int PIPE_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  acc_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      data_in1,
    input  logic [WIDTH-1:0]      data_in2,
    input  logic [WIDTH-1:0]      data_in3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    input  logic [NoConfigBits:0] ConfigBits
);
    logic [OPC_W-1:0]                 op;
    logic                             sel, run, accept;
    logic [WIDTH-1:0]                 addend, result, acc_q, acc_d;
    logic [PIPE_DEPTH-1:0]            valid, rdy, free, vin;
    logic [PIPE_DEPTH-1:0][WIDTH-1:0] dq, din;

    always_comb begin
        op     = ConfigBits[OPC_W-1:0];
        sel    = ConfigBits[ADDEND_SEL];
        run    = en && !rst;
        accept = in_valid && in_ready;
        // A clear coinciding with an accumulating op zeroes the accumulator addend.
        addend = sel ? data_in3 : (acc_clr ? '0 : acc_q);
        result = '0;
        case (op)
            OP_ADD: result = data_in1 + data_in2;
            OP_SUB: result = data_in1 - data_in2;
            OP_AND: result = data_in1 & data_in2;
            OP_OR:  result = data_in1 | data_in2;
            OP_XOR: result = data_in1 ^ data_in2;
            OP_MUL: result = data_in1 * data_in2;
            OP_MAC: result = data_in1 * data_in2 + addend;
            OP_ACC: result = data_in1 + addend;
            default: result = '0;
        endcase
        acc_d = !run ? acc_q
              : (accept && is_acc_op(op) && !sel) ? result
              : acc_clr ? '0 : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    // free[k]: something downstream of stage k will move this cycle.
    always_comb begin : ready_chain
        logic f;
        f = out_ready;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            free[k] = f;
            f = f || !valid[k];
        end
        vin[0] = in_valid;
        din[0] = result;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            vin[k] = valid[k-1];
            din[k] = dq[k-1];
        end
    end

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        pipe_alu_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (run),
            .ready_in  (free[i]),
            .valid_in  (vin[i]),
            .data_in   (din[i]),
            .ready_out (rdy[i]),
            .valid_out (valid[i]),
            .data_out  (dq[i])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid[PIPE_DEPTH-1];
    assign data_out  = dq[PIPE_DEPTH-1];
endmodule
